md_unit: RTL and testbench

//  E-stage multiply/divide unit: executes mult/multu/div/divu over a fixed multi-cycle latency and owns HI/LO.

---
 rtl/md_unit.sv | 121 ++++++++++++
 tb/tb_md_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO and runs mult/multu/div/divu over a fixed
// Busy window, committing the 64-bit result when the window closes.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOPE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MDUOutE,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2(MULT_CYCLES + DIV_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   hi_reg, hi_next, lo_reg, lo_next;
    logic [31:0]   pend_hi_reg, pend_hi_next, pend_lo_reg, pend_lo_next;
    logic          pend_keep_reg, pend_keep_next;

    // One-hot decode of the meaningful opcodes; 0 and 9..15 decode to nothing.
    logic [8:1] op_hot;
    genvar gi;
    generate
        for (gi = 1; gi <= 8; gi++) begin : g_dec
            assign op_hot[gi] = (MDUOPE == 4'(gi));
        end
    endgenerate

    logic is_mul, is_dv;
    assign is_mul = op_hot[1] | op_hot[2];
    assign is_dv  = op_hot[3] | op_hot[4];

    logic [63:0] op_a, op_b, prod;
    assign op_a = op_hot[2] ? {32'd0, RD1E} : {{32{RD1E[31]}}, RD1E};
    assign op_b = op_hot[2] ? {32'd0, RD2E} : {{32{RD2E[31]}}, RD2E};
    assign prod = op_a * op_b;

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
    logic [31:0] a_mag, b_mag, quot, rem, quot_fix, rem_fix;
    logic        div_zero;
    assign div_zero = (RD2E == 32'd0);
    assign a_mag    = (op_hot[3] && RD1E[31]) ? -RD1E : RD1E;
    assign b_mag    = (op_hot[3] && RD2E[31]) ? -RD2E : RD2E;
    assign quot     = div_zero ? 32'd0 : a_mag / b_mag;
    assign rem      = div_zero ? 32'd0 : a_mag % b_mag;
    assign quot_fix = (op_hot[3] && (RD1E[31] ^ RD2E[31])) ? -quot : quot;
    assign rem_fix  = (op_hot[3] && RD1E[31]) ? -rem : rem;

    assign Start   = (is_mul | is_dv) && (state_reg == IDLE);
    assign Busy    = Start | (state_reg == RUN);
    assign MDUOutE = op_hot[5] ? hi_reg : (op_hot[6] ? lo_reg : 32'd0);
    assign HI      = hi_reg;
    assign LO      = lo_reg;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        pend_hi_next   = pend_hi_reg;
        pend_lo_next   = pend_lo_reg;
        pend_keep_next = pend_keep_reg;
        unique case (state_reg)
            IDLE: begin
                if (Start) begin
                    pend_hi_next   = is_mul ? prod[63:32] : rem_fix;
                    pend_lo_next   = is_mul ? prod[31:0]  : quot_fix;
                    pend_keep_next = is_dv && div_zero;
                    count_next     = is_mul ? MULT_LOAD : DIV_LOAD;
                    state_next     = RUN;
                end else if (op_hot[7]) begin
                    hi_next = RD1E;
                end else if (op_hot[8]) begin
                    lo_next = RD1E;
                end
            end
            RUN: begin
                count_next = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    // A divide by zero still spends its window but leaves HI/LO alone.
                    if (!pend_keep_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            pend_hi_reg   <= '0;
            pend_lo_reg   <= '0;
            pend_keep_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            pend_hi_reg   <= pend_hi_next;
            pend_lo_reg   <= pend_lo_next;
            pend_keep_reg <= pend_keep_next;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver predicts each cycle's outputs from a cycle-count
// model of HI/LO and pushes them; a negedge monitor pops and compares.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOPE;
    logic [31:0] RD1E, RD2E;
    logic        Start, Busy;
    logic [31:0] MDUOutE, HI, LO;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .MDUOPE(MDUOPE), .RD1E(RD1E), .RD2E(RD2E),
        .Start(Start), .Busy(Busy), .MDUOutE(MDUOutE), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic        start;
        logic        busy;
        logic [31:0] out;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: architectural HI/LO plus a pending result that lands at cycle done_cyc.
    longint      cyc = 0;
    longint      done_cyc = 0;
    bit          pend = 0;
    bit          p_keep = 0;
    logic [31:0] p_hi = 0, p_lo = 0, m_hi = 0, m_lo = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        bit          busyq, st;
        longint      sa, sb, sp;
        logic [63:0] up;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        MDUOPE = op;
        RD1E   = a;
        RD2E   = b;
        if (pend && cyc >= done_cyc) begin
            if (!p_keep) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            pend = 0;
        end
        busyq   = pend;
        st      = (op >= 4'd1 && op <= 4'd4) && !busyq;
        e.op    = op;
        e.start = st;
        e.busy  = st || busyq;
        e.out   = (op == 4'd5) ? m_hi : ((op == 4'd6) ? m_lo : 32'd0);
        e.hi    = m_hi;
        e.lo    = m_lo;
        sbq.push_back(e);
        if (st) begin
            pend   = 1;
            p_keep = 0;
            sa     = longint'($signed(a));
            sb     = longint'($signed(b));
            case (op)
                4'd1: begin
                    sp = sa * sb;
                    {p_hi, p_lo} = sp;
                end
                4'd2: begin
                    up = {32'd0, a} * {32'd0, b};
                    {p_hi, p_lo} = up;
                end
                4'd3: begin
                    if (b == 0) p_keep = 1;
                    else begin
                        sp = sa / sb;
                        p_lo = sp[31:0];
                        sp = sa % sb;
                        p_hi = sp[31:0];
                    end
                end
                default: begin
                    if (b == 0) p_keep = 1;
                    else begin
                        p_lo = a / b;
                        p_hi = a % b;
                    end
                end
            endcase
            done_cyc = cyc + ((op <= 4'd2) ? MULT_N : DIV_N);
        end else if (!busyq && op == 4'd7) begin
            m_hi = a;
        end else if (!busyq && op == 4'd8) begin
            m_lo = a;
        end
        cyc++;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(4'd0, $urandom, $urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        MDUOPE = 4'd0;
        m_hi = 0;
        m_lo = 0;
        pend = 0;
        cyc++;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one line per transaction, compared against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                $display("txn op=%0d start=%0b busy=%0b out=%h hi=%h lo=%h",
                         e.op, Start, Busy, MDUOutE, HI, LO);
                chk("start", {31'd0, Start}, {31'd0, e.start});
                chk("busy",  {31'd0, Busy},  {31'd0, e.busy});
                chk("mduout", MDUOutE, e.out);
                chk("hi", HI, e.hi);
                chk("lo", LO, e.lo);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [3:0] op;
        logic [31:0] a, b;
        reset  = 1'b1;
        MDUOPE = 4'd0;
        RD1E   = 32'd0;
        RD2E   = 32'd0;
        repeat (3) @(posedge clk);

        // Reset state, then mult -3*5 and mflo on the first free cycle.
        issue(4'd0, 0, 0);
        issue(4'd1, 32'hFFFF_FFFD, 32'd5);
        nops(MULT_N - 1);
        issue(4'd6, 0, 0);
        @(negedge clk);
        chk("t1_mflo", MDUOutE, 32'hFFFF_FFF1);
        chk("t1_hi", HI, 32'hFFFF_FFFF);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        nops(MULT_N);
        @(negedge clk);
        chk("t2_hi", HI, 32'h0000_0001);
        chk("t2_lo", LO, 32'hFFFF_FFFE);

        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        nops(DIV_N);
        @(negedge clk);
        chk("t3_lo", LO, 32'hFFFF_FFFD);
        chk("t3_hi", HI, 32'h0000_0001);
        issue(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        nops(DIV_N);
        @(negedge clk);
        chk("t3u_lo", LO, 32'h0000_0000);
        chk("t3u_hi", HI, 32'h8000_0000);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        nops(DIV_N);

        // Divide by zero keeps HI; mthi then mfhi.
        issue(4'd7, 32'h55, 0);
        issue(4'd4, 32'd123, 32'd0);
        nops(DIV_N - 1);
        issue(4'd5, 0, 0);
        @(negedge clk);
        chk("t4_hi_kept", MDUOutE, 32'h55);
        issue(4'd7, 32'h1234, 0);
        issue(4'd5, 0, 0);
        @(negedge clk);
        chk("t4_mfhi", MDUOutE, 32'h1234);

        // Reset during the 4th Busy cycle of a divide.
        issue(4'd3, 32'd100, 32'd7);
        nops(2);
        do_reset();
        issue(4'd0, 0, 0);
        @(negedge clk);
        chk("t5_busy", {31'd0, Busy}, 32'd0);
        chk("t5_hi", HI, 32'd0);
        issue(4'd1, 32'd6, 32'd7);
        nops(MULT_N - 1);
        issue(4'd6, 0, 0);
        @(negedge clk);
        chk("t5_mult", MDUOutE, 32'd42);

        // mtlo held during a mult is ignored until the unit frees up on cycle 6.
        issue(4'd1, 32'd3, 32'd4);
        for (int i = 0; i < MULT_N - 1; i++) issue(4'd8, 32'h99, 0);
        issue(4'd8, 32'h99, 0);
        @(negedge clk);
        chk("t6_busy", {31'd0, Busy}, 32'd0);
        chk("t6_lo", LO, 32'd12);
        issue(4'd6, 0, 0);
        @(negedge clk);
        chk("t6_mtlo", MDUOutE, 32'h99);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      op = 4'($urandom_range(1, 4));
            else if (r < 55) op = 4'($urandom_range(5, 6));
            else if (r < 65) op = 4'($urandom_range(7, 8));
            else             op = 4'($urandom_range(0, 15));
            a = rnd_operand();
            b = rnd_operand();
            if ($urandom_range(0, 99) == 0) do_reset();
            else issue(op, a, b);
        end
        nops(DIV_N);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
